// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the ID/EX operand stage: ALU op codes, bit
// positions inside the 5-bit decoded control word, and the operand
// forward-select encoding.
// No ports (package).
package mips_pkg;

  // ALU operation codes driven on alu_control
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_GT  = 4'b0111;
  localparam logic [3:0] ALU_LT  = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1001;

  // Control word is {reg_write, mem_read, mem_write, mem_to_reg, alu_src}
  localparam int CTRL_W          = 5;
  localparam int CTRL_REG_WRITE  = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 1;
  localparam int CTRL_ALU_SRC    = 0;

  typedef enum logic [1:0] {
    FWD_REG   = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if
// Bundles everything the operand stage exchanges with the rest of the
// pipeline: pipeline control (flush/hold), the decoded ID instruction,
// the two forwarding sources, and the ALU / EX-MEM facing results.
// Modports:
//   master - pipeline side: drives ID, forwarding and control, reads results
//   slave  - the operand stage itself
interface id_ex_operand_stage_if #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
);

  logic                        flush;
  logic                        hold;
  logic                        id_valid;
  logic [mips_pkg::CTRL_W-1:0] id_ctrl;
  logic                        id_reg_dst;
  logic                        id_uses_rt;
  logic [3:0]                  id_alu_control;
  logic [RA_W-1:0]             id_shamt;
  logic [RA_W-1:0]             id_rs;
  logic [RA_W-1:0]             id_rt;
  logic [RA_W-1:0]             id_rd;
  logic [DATA_W-1:0]           id_rs_data;
  logic [DATA_W-1:0]           id_rt_data;
  logic [DATA_W-1:0]           id_imm;

  logic                        exmem_reg_write;
  logic [RA_W-1:0]             exmem_rd;
  logic [DATA_W-1:0]           exmem_result;
  logic                        memwb_reg_write;
  logic [RA_W-1:0]             memwb_rd;
  logic [DATA_W-1:0]           memwb_result;

  logic [DATA_W-1:0]           alu_data1;
  logic [DATA_W-1:0]           alu_data2;
  logic [3:0]                  alu_control;
  logic [RA_W-1:0]             shift_amount;
  logic                        ex_valid;
  logic [mips_pkg::CTRL_W-1:0] ex_ctrl;
  logic [RA_W-1:0]             ex_dest;
  logic [DATA_W-1:0]           ex_store_data;
  logic                        load_use_stall;

  modport master (
    output flush, hold, id_valid, id_ctrl, id_reg_dst, id_uses_rt,
           id_alu_control, id_shamt, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  alu_data1, alu_data2, alu_control, shift_amount,
           ex_valid, ex_ctrl, ex_dest, ex_store_data, load_use_stall
  );

  modport slave (
    input  flush, hold, id_valid, id_ctrl, id_reg_dst, id_uses_rt,
           id_alu_control, id_shamt, id_rs, id_rt, id_rd,
           id_rs_data, id_rt_data, id_imm,
           exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output alu_data1, alu_data2, alu_control, shift_amount,
           ex_valid, ex_ctrl, ex_dest, ex_store_data, load_use_stall
  );

endinterface

// File: rtl/fwd_select.sv
// fwd_select
// Chooses where one EX operand should come from: the value registered
// at ID/EX, the EX/MEM result, or the MEM/WB result.
// Ports:
//   i_reg             - register address the operand was read from
//   i_exmem_reg_write - EX/MEM instruction writes a register
//   i_exmem_rd        - EX/MEM destination register
//   i_memwb_reg_write - MEM/WB instruction writes a register
//   i_memwb_rd        - MEM/WB destination register
//   o_sel             - forward select (FWD_REG / FWD_EXMEM / FWD_MEMWB)
module fwd_select
  import mips_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] i_reg,
  input  logic            i_exmem_reg_write,
  input  logic [RA_W-1:0] i_exmem_rd,
  input  logic            i_memwb_reg_write,
  input  logic [RA_W-1:0] i_memwb_rd,
  output fwd_sel_e        o_sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  // r0 is hardwired to zero, so a write "to" it must never be forwarded
  assign w_exmem_hit = i_exmem_reg_write & (i_exmem_rd != '0) & (i_exmem_rd == i_reg);
  assign w_memwb_hit = i_memwb_reg_write & (i_memwb_rd != '0) & (i_memwb_rd == i_reg);

  // EX/MEM holds the younger producer, so it takes precedence
  always_comb begin
    o_sel = FWD_REG;
    if (w_exmem_hit) begin
      o_sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline register with RAW forwarding from EX/MEM and MEM/WB and
// load-use hazard detection. Feeds the 32-bit ALU directly.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset; clears all registered state
//   bus   - id_ex_operand_stage_if.slave: flush/hold, ID instruction,
//           forwarding sources, ALU operands/controls, EX-MEM controls,
//           store data and load_use_stall
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input logic                   clk,
  input logic                   reset,
  id_ex_operand_stage_if.slave  bus
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [RA_W-1:0]   r_dest;
  logic [3:0]        r_alu_control;
  logic [RA_W-1:0]   r_shamt;
  logic [RA_W-1:0]   r_rs;
  logic [RA_W-1:0]   r_rt;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;

  logic              w_load_use;
  logic              w_bubble;
  logic [RA_W-1:0]   w_id_dest;
  fwd_sel_e          w_sel_rs;
  fwd_sel_e          w_sel_rt;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // A load in EX produces its value too late for a dependent instruction
  // in ID, even with forwarding; that pair must be split by one bubble.
  assign w_load_use = r_valid & r_ctrl[CTRL_MEM_READ] & (r_dest != '0) & bus.id_valid &
                      ((r_dest == bus.id_rs) | (bus.id_uses_rt & (r_dest == bus.id_rt)));

  assign w_bubble  = bus.flush | w_load_use;
  assign w_id_dest = bus.id_reg_dst ? bus.id_rd : bus.id_rt;

  // Flush overrides hold; a bubble still captures the data fields since
  // a zero control word makes them harmless.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_ctrl        <= '0;
      r_dest        <= '0;
      r_alu_control <= ALU_ADD;
      r_shamt       <= '0;
      r_rs          <= '0;
      r_rt          <= '0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
    end else if (bus.flush || !bus.hold) begin
      r_alu_control <= bus.id_alu_control;
      r_shamt       <= bus.id_shamt;
      r_rs          <= bus.id_rs;
      r_rt          <= bus.id_rt;
      r_rs_data     <= bus.id_rs_data;
      r_rt_data     <= bus.id_rt_data;
      r_imm         <= bus.id_imm;
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        r_dest  <= '0;
      end else begin
        r_valid <= bus.id_valid;
        r_ctrl  <= bus.id_ctrl;
        r_dest  <= w_id_dest;
      end
    end
  end

  fwd_select #(.RA_W(RA_W)) u_fwd_rs (
    .i_reg             (r_rs),
    .i_exmem_reg_write (bus.exmem_reg_write),
    .i_exmem_rd        (bus.exmem_rd),
    .i_memwb_reg_write (bus.memwb_reg_write),
    .i_memwb_rd        (bus.memwb_rd),
    .o_sel             (w_sel_rs)
  );

  fwd_select #(.RA_W(RA_W)) u_fwd_rt (
    .i_reg             (r_rt),
    .i_exmem_reg_write (bus.exmem_reg_write),
    .i_exmem_rd        (bus.exmem_rd),
    .i_memwb_reg_write (bus.memwb_reg_write),
    .i_memwb_rd        (bus.memwb_rd),
    .o_sel             (w_sel_rt)
  );

  always_comb begin
    w_fwd_rs = r_rs_data;
    case (w_sel_rs)
      FWD_EXMEM: w_fwd_rs = bus.exmem_result;
      FWD_MEMWB: w_fwd_rs = bus.memwb_result;
      default:   w_fwd_rs = r_rs_data;
    endcase
  end

  always_comb begin
    w_fwd_rt = r_rt_data;
    case (w_sel_rt)
      FWD_EXMEM: w_fwd_rt = bus.exmem_result;
      FWD_MEMWB: w_fwd_rt = bus.memwb_result;
      default:   w_fwd_rt = r_rt_data;
    endcase
  end

  assign bus.alu_data1      = w_fwd_rs;
  assign bus.alu_data2      = r_ctrl[CTRL_ALU_SRC] ? r_imm : w_fwd_rt;
  assign bus.ex_store_data  = w_fwd_rt;
  assign bus.alu_control    = r_alu_control;
  assign bus.shift_amount   = r_shamt;
  assign bus.ex_valid       = r_valid;
  assign bus.ex_ctrl        = r_ctrl;
  assign bus.ex_dest        = r_dest;
  assign bus.load_use_stall = w_load_use;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage
// Directed plus randomized bench for id_ex_operand_stage. A behavioural
// model of the EX-stage instruction and the forwarding/hazard rules
// predicts every output.
module tb_id_ex_operand_stage;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  id_ex_operand_stage_if #(.DATA_W(32), .RA_W(5)) bus ();

  id_ex_operand_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model of the instruction currently sitting in EX
  logic        m_valid;
  logic [4:0]  m_ctrl;
  logic [4:0]  m_dest;
  logic [3:0]  m_alu;
  logic [4:0]  m_shamt;
  logic [4:0]  m_rs;
  logic [4:0]  m_rt;
  logic [31:0] m_rsd;
  logic [31:0] m_rtd;
  logic [31:0] m_imm;
  bit          m_known;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Value an operand register really has right now: youngest in-flight
  // writer wins, r0 always reads its stored value.
  function automatic logic [31:0] operandValue(input logic [4:0] r, input logic [31:0] stored);
    if (r == 5'd0) return stored;
    if (bus.exmem_reg_write && bus.exmem_rd == r) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd == r) return bus.memwb_result;
    return stored;
  endfunction

  function automatic bit stallModel();
    bit isLoad;
    bit dep;
    isLoad = m_valid && m_ctrl[CTRL_MEM_READ] && (m_dest != 5'd0);
    dep    = (m_dest == bus.id_rs) || (bus.id_uses_rt && (m_dest == bus.id_rt));
    return isLoad && bus.id_valid && dep;
  endfunction

  task automatic modelReset();
    m_valid = 0; m_ctrl = 0; m_dest = 0; m_alu = 0; m_shamt = 0;
    m_rs = 0; m_rt = 0; m_rsd = 0; m_rtd = 0; m_imm = 0; m_known = 1;
  endtask

  task automatic modelClock();
    bit bubble;
    if (bus.flush || !bus.hold) begin
      bubble  = bus.flush || stallModel();
      m_alu   = bus.id_alu_control;
      m_shamt = bus.id_shamt;
      m_rs    = bus.id_rs;
      m_rt    = bus.id_rt;
      m_rsd   = bus.id_rs_data;
      m_rtd   = bus.id_rt_data;
      m_imm   = bus.id_imm;
      if (bubble) begin
        m_valid = 0; m_ctrl = 0; m_dest = 0; m_known = 0;
      end else begin
        m_valid = bus.id_valid;
        m_ctrl  = bus.id_ctrl;
        m_dest  = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        m_known = 1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] rtv;
    check({tag, ".valid"}, 32'(bus.ex_valid), 32'(m_valid));
    check({tag, ".ctrl"},  32'(bus.ex_ctrl),  32'(m_ctrl));
    check({tag, ".dest"},  32'(bus.ex_dest),  32'(m_dest));
    check({tag, ".stall"}, 32'(bus.load_use_stall), 32'(stallModel()));
    if (m_known) begin
      rtv = operandValue(m_rt, m_rtd);
      check({tag, ".d1"},    bus.alu_data1, operandValue(m_rs, m_rsd));
      check({tag, ".d2"},    bus.alu_data2, m_ctrl[CTRL_ALU_SRC] ? m_imm : rtv);
      check({tag, ".store"}, bus.ex_store_data, rtv);
      check({tag, ".aluc"},  32'(bus.alu_control), 32'(m_alu));
      check({tag, ".shamt"}, 32'(bus.shift_amount), 32'(m_shamt));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [4:0] ctrl, input logic regDst,
                               input logic usesRt, input logic [3:0] aluc, input logic [4:0] sh,
                               input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
    bus.id_valid = v; bus.id_ctrl = ctrl; bus.id_reg_dst = regDst; bus.id_uses_rt = usesRt;
    bus.id_alu_control = aluc; bus.id_shamt = sh; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm = imm;
  endtask

  task automatic setFwd(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                        input logic ww, input logic [4:0] wrd, input logic [31:0] wres);
    bus.exmem_reg_write = ew; bus.exmem_rd = erd; bus.exmem_result = eres;
    bus.memwb_reg_write = ww; bus.memwb_rd = wrd; bus.memwb_result = wres;
  endtask

  task automatic randomId();
    applyStimulus($urandom_range(0, 9) != 0, 5'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom_range(0, 9)), 5'($urandom), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    modelClock();
    @(negedge clk);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b1;
    bus.flush = 0; bus.hold = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    setFwd(0, 0, 0, 0, 0, 0);
    modelReset();
    #1;
    checkOutput("reset");
    check("reset.aluc0", 32'(bus.alu_control), 32'(ALU_ADD));
    @(negedge clk);
    reset = 1'b0;

    // add r3,r1,r2 with r1=5, r2=7
    applyStimulus(1, 5'b10000, 1, 1, ALU_ADD, 0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
    step("add");
    check("add.d1c", bus.alu_data1, 32'd5);
    check("add.d2c", bus.alu_data2, 32'd7);
    check("add.destc", 32'(bus.ex_dest), 32'd3);
    check("add.alucc", 32'(bus.alu_control), 32'(ALU_ADD));

    // both forwarding sources target r1: EX/MEM wins
    setFwd(1, 5'd1, 32'd100, 1, 5'd1, 32'd200);
    #1;
    check("dh.d1c", bus.alu_data1, 32'd100);
    checkOutput("dh");
    setFwd(1, 5'd0, 32'd100, 1, 5'd0, 32'd200);
    #1;
    check("dh0.d1c", bus.alu_data1, 32'd5);
    checkOutput("dh0");
    setFwd(0, 0, 0, 0, 0, 0);

    // lw r4,0x20(r1) then dependent add r5,r4,r6
    applyStimulus(1, 5'b11011, 0, 0, ALU_ADD, 0, 5'd1, 5'd4, 5'd9, 32'h10, 32'h0, 32'h20);
    step("lw");
    check("lw.destc", 32'(bus.ex_dest), 32'd4);
    applyStimulus(1, 5'b10000, 1, 1, ALU_ADD, 0, 5'd4, 5'd6, 5'd5, 32'h11, 32'h22, 32'h0);
    #1;
    check("lu.stallc", 32'(bus.load_use_stall), 32'd1);
    step("lu.bubble");
    check("lu.validc", 32'(bus.ex_valid), 32'd0);
    check("lu.ctrlc", 32'(bus.ex_ctrl), 32'd0);
    setFwd(0, 0, 0, 1, 5'd4, 32'h44);
    step("lu.add");
    check("lu.d1c", bus.alu_data1, 32'h44);
    check("lu.d2c", bus.alu_data2, 32'h22);
    check("lu.destc", 32'(bus.ex_dest), 32'd5);
    setFwd(0, 0, 0, 0, 0, 0);

    // sw r2,8(r1) with r2 forwarded from EX/MEM
    applyStimulus(1, 5'b00101, 0, 1, ALU_ADD, 0, 5'd1, 5'd2, 5'd0, 32'h1000, 32'h99, 32'd8);
    step("sw");
    setFwd(1, 5'd2, 32'hDEADBEEF, 0, 0, 0);
    #1;
    check("sw.d2c", bus.alu_data2, 32'd8);
    check("sw.storec", bus.ex_store_data, 32'hDEADBEEF);
    check("sw.d1c", bus.alu_data1, 32'h1000);
    checkOutput("sw.fwd");

    // hold freezes the stage while ID keeps changing
    bus.hold = 1;
    for (int i = 0; i < 3; i++) begin
      randomId();
      step("hold");
      check("hold.destc", 32'(bus.ex_dest), 32'd2);
      check("hold.storec", bus.ex_store_data, 32'hDEADBEEF);
    end
    bus.flush = 1;
    step("flushhold");
    check("fh.validc", 32'(bus.ex_valid), 32'd0);
    check("fh.ctrlc", 32'(bus.ex_ctrl), 32'd0);
    check("fh.destc", 32'(bus.ex_dest), 32'd0);
    bus.flush = 0; bus.hold = 0;
    setFwd(0, 0, 0, 0, 0, 0);

    // flush together with a load-use hazard
    applyStimulus(1, 5'b11011, 0, 0, ALU_ADD, 0, 5'd1, 5'd4, 5'd9, 32'h10, 32'h0, 32'h20);
    step("lw2");
    applyStimulus(1, 5'b10000, 1, 1, ALU_ADD, 0, 5'd6, 5'd4, 5'd5, 32'h11, 32'h22, 32'h0);
    bus.flush = 1;
    #1;
    check("fl.stallc", 32'(bus.load_use_stall), 32'd1);
    step("fl.bubble");
    check("fl.validc", 32'(bus.ex_valid), 32'd0);
    bus.flush = 0;

    // randomized traffic with small register numbers to provoke hazards
    for (int i = 0; i < 300; i++) begin
      randomId();
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.hold  = ($urandom_range(0, 5) == 0);
      setFwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      step("rand");
    end

    // reset arriving mid-cycle during a load-use stall
    bus.flush = 0; bus.hold = 0;
    setFwd(0, 0, 0, 0, 0, 0);
    applyStimulus(1, 5'b11011, 0, 0, ALU_ADD, 5'd3, 5'd1, 5'd4, 5'd9, 32'h10, 32'h0, 32'h20);
    step("lw3");
    applyStimulus(1, 5'b10000, 1, 1, ALU_ADD, 0, 5'd4, 5'd6, 5'd5, 32'h11, 32'h22, 32'h0);
    #1;
    check("rs.stallc", 32'(bus.load_use_stall), 32'd1);
    #1;
    reset = 1'b1;
    modelReset();
    #1;
    check("rs.stall0", 32'(bus.load_use_stall), 32'd0);
    check("rs.valid0", 32'(bus.ex_valid), 32'd0);
    check("rs.d1zero", bus.alu_data1, 32'd0);
    checkOutput("rs");
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand forwarding, directly upstream of the 32-bit ALU.
- Registers decoded operands and controls at each clock edge.
- Resolves RAW hazards by forwarding from EX/MEM and MEM/WB, then drives the ALU's data1, data2, ALUControl and shiftAmount.
- Detects load-use hazards, stalls the front end and inserts a bubble.

Parameters:
- DATA_W, 32, operand/result width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  branch/exception flush; next EX content is a bubble.
- hold  in  1  global memory stall; freeze stage contents.
- id_valid  in  1  ID holds a real instruction.
- id_ctrl  in  5  {reg_write, mem_read, mem_write, mem_to_reg, alu_src}.
- id_reg_dst  in  1  1: dest=rd, 0: dest=rt.
- id_uses_rt  in  1  instruction reads rt (R-type, store, beq).
- id_alu_control  in  4  ALU op code.
- id_shamt  in  RA_W  shift amount.
- id_rs, id_rt, id_rd  in  RA_W  register addresses.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign-extended immediate.
- exmem_reg_write  in  1, exmem_rd  in  RA_W, exmem_result  in  DATA_W  EX/MEM forwarding source.
- memwb_reg_write  in  1, memwb_rd  in  RA_W, memwb_result  in  DATA_W  MEM/WB forwarding source.
- alu_data1, alu_data2  out  DATA_W  ALU operands.
- alu_control  out  4, shift_amount  out  RA_W  to ALU.
- ex_valid  out  1, ex_ctrl  out  5, ex_dest  out  RA_W  passed to EX/MEM.
- ex_store_data  out  DATA_W  forwarded rt value for stores.
- load_use_stall  out  1  freeze PC and IF/ID.

Behaviour:
- Reset (async): all registered state is 0. ex_valid=0, ex_ctrl=0, ex_dest=0, alu_control=0 (ADD), shift_amount=0, stored operands=0. alu_data1/alu_data2/ex_store_data therefore read 0 unless forwarded; forwarding cannot fire because reg_write sources are 0 at reset.
- Load-use hazard (combinational): load_use_stall = ex_valid & ex_ctrl.mem_read & ex_dest!=0 & id_valid & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
- Edge update, in priority order:
  - flush: load a bubble (valid=0, ctrl=0, dest=0).
  - hold: keep all state.
  - load_use_stall: load a bubble.
  - otherwise: load the ID fields, with dest = id_reg_dst ? id_rd : id_rt.
- A bubble still loads the data fields (don't-care), but ctrl=0 so the bubble has no side effects.
- Forwarding (combinational on registered rs/rt), per operand:
  - Select EX/MEM when exmem_reg_write & exmem_rd!=0 & exmem_rd==reg.
  - Otherwise select MEM/WB under the same conditions on memwb_*.
  - Otherwise use the registered value.
  - EX/MEM wins when both match. Register 0 is never forwarded.
- Operand outputs:
  - alu_data1 = forwarded rs.
  - ex_store_data = forwarded rt.
  - alu_data2 = alu_src ? registered imm : forwarded rt.
- Latency: operands are registered 1 cycle after ID; forwarding adds no cycle.
- Simultaneous flush and load_use_stall: flush wins, and load_use_stall is still asserted that cycle; the front end resolves it.
- Reset mid-stall: load_use_stall drops immediately because ex_valid=0.

Decomposition:
- mips_pkg holds:
  - ALU op constants ADD=0000, SUB=0001, AND=0010, OR=0011, SLL=0100, SRL=0101, SRA=0110, GT=0111, LT=1000, NOR=1001.
  - id_ctrl bit indices.
  - Forward-select enum FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2.
- One sub-module, fwd_select: reg address + both sources → 2-bit select, instantiated twice (rs and rt).

Test Plan:
- reset asserted mid-cycle with valid state loaded → all outputs 0 asynchronously; ex_valid=0; load_use_stall=0.
- ID add r3,r1,r2 with r1=5, r2=7, no forwarding → next cycle alu_data1=5, alu_data2=7, ex_dest=3, alu_control=0000.
- Double hazard: exmem_rd=1 result=100 and memwb_rd=1 result=200, both reg_write=1 → alu_data1=100. Same with exmem_rd=0 and memwb_rd=0 → no forwarding, registered value used.
- EX holds lw r4 (mem_read=1), ID add r5,r4,r6 → load_use_stall=1; next edge ex_valid=0, ctrl=0. With ID held, the following cycle loads add and memwb_rd=4 forwards.
- Store sw r2,8(r1) with alu_src=1, imm=8, exmem_rd=2 result=0xDEADBEEF → alu_data2=8, ex_store_data=0xDEADBEEF.
- hold=1 for 3 cycles with ID changing → EX outputs unchanged. Same cycle flush=1 and hold=1 → bubble loaded.
